// File: rtl/step_pulse_rx_if.sv
// Bundle of the step-pulse receiver's control inputs and status outputs.
// exp_valid/start/clr are single-clock strobes with no ready: the receiver samples them every clk edge.
interface step_pulse_rx_if #(
    parameter int CNT_W = 16
);
    logic             step_in;
    logic [CNT_W-1:0] N_exp;
    logic             exp_valid;
    logic             start;
    logic             clr;
    logic [CNT_W-1:0] count;
    logic             busy;
    logic             done;
    logic             err_over;
    logic             err_timeout;

    modport slave (
        input  step_in, N_exp, exp_valid, start, clr,
        output count, busy, done, err_over, err_timeout
    );

    modport master (
        output step_in, N_exp, exp_valid, start, clr,
        input  count, busy, done, err_over, err_timeout
    );
endinterface

// File: rtl/step_pulse_rx.sv
// Step-pulse receiver: synchronises and de-glitches step_in, counts qualified pulses
// against a commanded count, and flags completion, overrun or stall.
module step_pulse_rx #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int MIN_HI      = 2,
    parameter int TO_W        = 20,
    parameter int TIMEOUT     = 100000
) (
    input  logic          clk,
    input  logic          rst,
    step_pulse_rx_if.slave bus,
    output logic [1:0]    state_o
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    localparam int              HI_W    = $clog2(MIN_HI + 1);
    localparam logic [HI_W-1:0] HI_LAST = HI_W'(MIN_HI - 1);
    localparam logic [HI_W-1:0] HI_MAX  = HI_W'(MIN_HI);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   s_step;
    logic [HI_W-1:0]        hi_q, hi_d;
    logic                   p_evt;

    state_t           state_q;
    logic [CNT_W-1:0] n_reg_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_inc;
    logic [TO_W-1:0]  timer_q;
    logic             busy_q, done_q, err_over_q, err_timeout_q;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], bus.step_in};
    assign s_step = sync_q[SYNC_STAGES-1];

    // Run counter parks at MIN_HI so a long pulse yields exactly one event.
    always_comb begin
        hi_d = '0;
        if (s_step) begin
            hi_d = (hi_q == HI_MAX) ? hi_q : hi_q + 1'b1;
        end
    end

    // Event on the clock the run counter reaches MIN_HI, so the count lands
    // SYNC_STAGES+MIN_HI edges after the raw rising edge.
    assign p_evt     = s_step && (hi_q == HI_LAST);
    assign count_inc = (count_q == '1) ? count_q : count_q + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            hi_q   <= '0;
        end else begin
            sync_q <= sync_d;
            hi_q   <= hi_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            n_reg_q       <= '0;
            count_q       <= '0;
            timer_q       <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_over_q    <= 1'b0;
            err_timeout_q <= 1'b0;
        end else if (bus.clr) begin
            state_q       <= IDLE;
            count_q       <= '0;
            timer_q       <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_over_q    <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.exp_valid) begin
                        n_reg_q <= bus.N_exp;
                    end
                    if (bus.start) begin
                        count_q <= '0;
                        timer_q <= '0;
                        if (n_reg_q == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (p_evt) begin
                        count_q <= count_inc;
                        timer_q <= '0;
                        if (count_inc == n_reg_q) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end else if (timer_q == TO_LAST) begin
                        state_q       <= ERR;
                        busy_q        <= 1'b0;
                        err_timeout_q <= 1'b1;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                DONE: begin
                    if (p_evt) begin
                        count_q    <= count_inc;
                        state_q    <= ERR;
                        done_q     <= 1'b0;
                        err_over_q <= 1'b1;
                    end
                end
                ERR: begin
                    if (p_evt) begin
                        count_q <= count_inc;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign state_o         = state_q;
    assign bus.count       = count_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.err_over    = err_over_q;
    assign bus.err_timeout = err_timeout_q;
endmodule
